pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit_pkg.sv | 28 ++
 rtl/pipe_hazard_unit_src_cmp.sv | 49 ++++
 rtl/pipe_hazard_unit.sv | 94 +++++++++
 tb/tb_pipe_hazard_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select
// encodings, the per-stage tracking record and a writer-match helper.
package pipe_hazard_unit_pkg;

  // Operand source selection encodings driven on fwd_sel.
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Tracking records hold addresses zero-extended to this width, so the
  // unit supports any ADDR_W up to MAX_ADDR_W.
  localparam int unsigned MAX_ADDR_W = 16;

  // One pipeline stage's view of the instruction it holds.
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [MAX_ADDR_W-1:0] wa;
    logic                  is_load;
  } stage_t;

  // A stage writes 'addr' only if it holds a real, register-writing instruction.
  function automatic logic is_writer(input stage_t s, input logic [MAX_ADDR_W-1:0] addr);
    return s.valid && s.we && (s.wa == addr);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_src_cmp.sv
// Per-source hazard comparator: picks the forwarding source for one
// operand and flags whether that operand forces an interlock.
module hazard_src_cmp
  import pipe_hazard_unit_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic                  check,
  input  logic [MAX_ADDR_W-1:0] src,
  input  stage_t                ex,
  input  stage_t                mem,
  input  stage_t                wb,
  output logic [1:0]            fwd_sel,
  output logic                  hazard
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_load_bits;

  assign ex_hit  = check && is_writer(ex, src);
  assign mem_hit = check && is_writer(mem, src);
  assign wb_hit  = check && is_writer(wb, src);

  // Older stages' load flags never matter: their data is already available.
  assign unused_load_bits = mem.is_load ^ wb.is_load;

  // Youngest matching writer wins; without forwarding, EX/MEM writers interlock.
  always_comb begin
    fwd_sel = FWD_RF;
    hazard  = 1'b0;
    if (FWD_EN != 0) begin
      if (ex_hit) begin
        fwd_sel = FWD_EX;
        hazard  = ex.is_load;
      end else if (mem_hit) begin
        fwd_sel = FWD_MEM;
      end else if (wb_hit) begin
        fwd_sel = FWD_WB;
      end else begin
        fwd_sel = FWD_RF;
      end
    end else begin
      hazard = ex_hit || mem_hit;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB writers, resolves operand
// forwarding per source, and generates stall/flush plus a stall counter.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rf_valid,
  input  logic                             rf_we,
  input  logic [ADDR_W-1:0]                rf_wa,
  input  logic                             rf_is_load,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]   rf_src_addr,
  input  logic [NUM_SRC-1:0]               rf_src_used,
  input  logic                             branch_taken,
  output logic [NUM_SRC-1:0][1:0]          fwd_sel,
  output logic                             stall,
  output logic                             flush,
  output logic                             ex_valid,
  output logic                             mem_valid,
  output logic                             wb_valid,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t               ex_r;
  stage_t               mem_r;
  stage_t               wb_r;
  stage_t               rf_stage_s;
  logic [NUM_SRC-1:0]   hazard_s;
  logic [CNT_W-1:0]     stall_cnt_r;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_cmp #(
      .FWD_EN (FWD_EN)
    ) u_cmp (
      .check   (rf_valid && rf_src_used[i]),
      .src     (MAX_ADDR_W'(rf_src_addr[i])),
      .ex      (ex_r),
      .mem     (mem_r),
      .wb      (wb_r),
      .fwd_sel (fwd_sel[i]),
      .hazard  (hazard_s[i])
    );
  end

  assign stall = |hazard_s;
  // A taken branch is only acted on once the RF instruction is allowed to move.
  assign flush = branch_taken && rf_valid && !stall;

  // Record entering EX; a stall turns it into a bubble (branch itself still enters).
  always_comb begin
    rf_stage_s         = '0;
    rf_stage_s.valid   = rf_valid && !stall;
    rf_stage_s.we      = rf_we;
    rf_stage_s.wa      = MAX_ADDR_W'(rf_wa);
    rf_stage_s.is_load = rf_is_load;
  end

  // Advance the tracking pipeline every cycle; reset discards all writers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      ex_r  <= rf_stage_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end
  end

  // Count stalled cycles, saturating at the counter's maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (stall && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign ex_valid  = ex_r.valid;
  assign mem_valid = mem_r.valid;
  assign wb_valid  = wb_r.valid;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: three configurations (default,
// interlock-only, 2-bit stall counter) share one stimulus stream and are
// each compared against an age-indexed instruction-history model.
module tb_pipe_hazard_unit;

  logic            clk = 1'b0;
  logic            reset;
  logic            rf_valid;
  logic            rf_we;
  logic [3:0]      rf_wa;
  logic            rf_is_load;
  logic [1:0][3:0] rf_src_addr;
  logic [1:0]      rf_src_used;
  logic            branch_taken;

  logic [1:0][1:0] fwd_a, fwd_b, fwd_c;
  logic            stall_a, stall_b, stall_c;
  logic            flush_a, flush_b, flush_c;
  logic            exv_a, exv_b, exv_c, memv_a, memv_b, memv_c, wbv_a, wbv_b, wbv_c;
  logic [15:0]     cnt_a, cnt_b;
  logic [1:0]      cnt_c;

  always #5 clk = ~clk;

  pipe_hazard_unit u_main (
    .clk(clk), .reset(reset), .rf_valid(rf_valid), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_is_load(rf_is_load), .rf_src_addr(rf_src_addr), .rf_src_used(rf_src_used),
    .branch_taken(branch_taken), .fwd_sel(fwd_a), .stall(stall_a), .flush(flush_a),
    .ex_valid(exv_a), .mem_valid(memv_a), .wb_valid(wbv_a), .stall_cnt(cnt_a)
  );

  pipe_hazard_unit #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .reset(reset), .rf_valid(rf_valid), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_is_load(rf_is_load), .rf_src_addr(rf_src_addr), .rf_src_used(rf_src_used),
    .branch_taken(branch_taken), .fwd_sel(fwd_b), .stall(stall_b), .flush(flush_b),
    .ex_valid(exv_b), .mem_valid(memv_b), .wb_valid(wbv_b), .stall_cnt(cnt_b)
  );

  pipe_hazard_unit #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(reset), .rf_valid(rf_valid), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_is_load(rf_is_load), .rf_src_addr(rf_src_addr), .rf_src_used(rf_src_used),
    .branch_taken(branch_taken), .fwd_sel(fwd_c), .stall(stall_c), .flush(flush_c),
    .ex_valid(exv_c), .mem_valid(memv_c), .wb_valid(wbv_c), .stall_cnt(cnt_c)
  );

  // Observed outputs gathered per configuration: 0 main, 1 no-forward, 2 small counter.
  logic [3:0]  o_fwd [3];
  logic        o_stall [3];
  logic        o_flush [3];
  logic [2:0]  o_val [3];
  logic [15:0] o_cnt [3];
  assign o_fwd[0] = fwd_a;  assign o_fwd[1] = fwd_b;  assign o_fwd[2] = fwd_c;
  assign o_stall[0] = stall_a; assign o_stall[1] = stall_b; assign o_stall[2] = stall_c;
  assign o_flush[0] = flush_a; assign o_flush[1] = flush_b; assign o_flush[2] = flush_c;
  assign o_val[0] = {wbv_a, memv_a, exv_a};
  assign o_val[1] = {wbv_b, memv_b, exv_b};
  assign o_val[2] = {wbv_c, memv_c, exv_c};
  assign o_cnt[0] = cnt_a; assign o_cnt[1] = cnt_b; assign o_cnt[2] = {14'd0, cnt_c};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of issued instructions indexed by age (1 = one
  // cycle ago, i.e. EX; 2 = MEM; 3 = WB) plus a stall tally per configuration.
  int fwd_en [3] = '{1, 0, 1};
  int cmax   [3] = '{65535, 65535, 3};
  int hv [3][4];
  int hwe[3][4];
  int hwa[3][4];
  int hld[3][4];
  int mcnt[3];

  // Values seen on the most recent step, for scenario-specific checks.
  logic [3:0]  last_fwd [3];
  logic        last_stall [3];
  logic        last_flush [3];
  logic [2:0]  last_val [3];
  logic [15:0] last_cnt [3];

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 4; a++) begin
        hv[k][a] = 0; hwe[k][a] = 0; hwa[k][a] = 0; hld[k][a] = 0;
      end
      mcnt[k] = 0;
    end
  endtask

  // Apply one cycle of RF-stage inputs, compare every configuration, then clock.
  task automatic step(input logic rst, input logic v, input logic we, input logic [3:0] wa,
                      input logic ld, input logic [3:0] s0, input logic [3:0] s1,
                      input logic [1:0] used, input logic br);
    int  exp_stall [3];
    int  src [2];
    int  youngest;
    logic [3:0] exp_fwd;
    reset = rst; rf_valid = v; rf_we = we; rf_wa = wa; rf_is_load = ld;
    rf_src_addr[0] = s0; rf_src_addr[1] = s1; rf_src_used = used; branch_taken = br;
    src[0] = int'(s0); src[1] = int'(s1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_stall[k] = 0;
      exp_fwd = 4'd0;
      for (int s = 0; s < 2; s++) begin
        youngest = 0;
        if (v && used[s]) begin
          for (int a = 3; a >= 1; a--) begin
            if (hv[k][a] != 0 && hwe[k][a] != 0 && hwa[k][a] == src[s]) youngest = a;
          end
        end
        if (fwd_en[k] != 0) begin
          exp_fwd[2*s +: 2] = 2'(youngest);
          if (youngest == 1 && hld[k][1] != 0) exp_stall[k] = 1;
        end else begin
          if (youngest == 1 || youngest == 2) exp_stall[k] = 1;
        end
      end
      check_val($sformatf("fwd_sel[c%0d]", k), 32'(o_fwd[k]), 32'(exp_fwd));
      check_val($sformatf("stall[c%0d]", k), 32'(o_stall[k]), 32'(exp_stall[k]));
      check_val($sformatf("flush[c%0d]", k), 32'(o_flush[k]),
                32'(br && v && exp_stall[k] == 0));
      check_val($sformatf("valids[c%0d]", k), 32'(o_val[k]),
                32'({hv[k][3] != 0, hv[k][2] != 0, hv[k][1] != 0}));
      check_val($sformatf("stall_cnt[c%0d]", k), 32'(o_cnt[k]), 32'(mcnt[k]));
      last_fwd[k] = o_fwd[k]; last_stall[k] = o_stall[k]; last_flush[k] = o_flush[k];
      last_val[k] = o_val[k]; last_cnt[k] = o_cnt[k];
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < 3; k++) begin
        for (int a = 3; a >= 2; a--) begin
          hv[k][a] = hv[k][a-1]; hwe[k][a] = hwe[k][a-1];
          hwa[k][a] = hwa[k][a-1]; hld[k][a] = hld[k][a-1];
        end
        hv[k][1]  = (v && exp_stall[k] == 0) ? 1 : 0;
        hwe[k][1] = int'(we); hwa[k][1] = int'(wa); hld[k][1] = int'(ld);
        if (exp_stall[k] != 0 && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rf_valid = 1'b0; rf_we = 1'b0; rf_wa = 4'd0; rf_is_load = 1'b0;
    rf_src_addr = '0; rf_src_used = 2'b00; branch_taken = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle(1'b1);
    idle(1'b0);
    check_val("reset_valids", 32'(last_val[0]), 32'd0);
    check_val("reset_cnt", 32'(last_cnt[0]), 32'd0);

    // ADD R3 then reader of R3: forwarded from EX, no stall
    step(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 4'd0, 2'b01, 1'b0);
    check_val("add_fwd_ex", 32'(last_fwd[0][1:0]), 32'd1);
    check_val("add_no_stall", 32'(last_stall[0]), 32'd0);
    idle(1'b1);

    // LDR R5 then reader: one stall, bubble in EX, then MEM forward
    step(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0);
    check_val("ldu_stall", 32'(last_stall[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0);
    check_val("ldu_release", 32'(last_stall[0]), 32'd0);
    check_val("ldu_bubble", 32'(last_val[0][0]), 32'd0);
    check_val("ldu_fwd_mem", 32'(last_fwd[0][1:0]), 32'd2);
    check_val("ldu_cnt", 32'(last_cnt[0]), 32'd1);
    idle(1'b1);

    // R2 in EX and WB, R4 in MEM: per-source youngest writer
    step(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 4'd4, 2'b11, 1'b0);
    check_val("multi_src_fwd", 32'(last_fwd[0]), 32'h9);
    idle(1'b1);

    // Interlock-only: ADD R1 then reader stalls two cycles with no forwarding
    step(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 4'd0, 2'b01, 1'b0);
      check_val($sformatf("nofwd_stall%0d", i), 32'(last_stall[1]), (i < 2) ? 32'd1 : 32'd0);
      check_val($sformatf("nofwd_sel%0d", i), 32'(last_fwd[1]), 32'd0);
    end
    idle(1'b1);

    // Branch held off by a load-use stall, resolved the next cycle
    step(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b1);
    check_val("br_during_stall", 32'(last_flush[0]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b1);
    check_val("br_after_stall", 32'(last_flush[0]), 32'd1);
    idle(1'b0);
    check_val("br_enters_ex", 32'(last_val[0][0]), 32'd1);
    idle(1'b1);

    // Five load-use stalls on the 2-bit counter: saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 2'b00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0);
    end
    idle(1'b0);
    check_val("cnt2_saturate", 32'(last_cnt[2]), 32'd3);
    check_val("cnt16_count", 32'(last_cnt[0]), 32'd5);

    // Reset in the middle of a load-use stall
    step(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0);
    check_val("rst_mid_stall_before", 32'(last_stall[2]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 2'b01, 1'b0);
    check_val("rst_mid_stall_drop", 32'(last_stall[2]), 32'd0);
    check_val("rst_cnt_clear", 32'(last_cnt[2]), 32'd0);
    check_val("rst_valids_clear", 32'(last_val[2]), 32'd0);

    // Randomized traffic over a small register set to provoke many hazards
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           2'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
